// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch -> decode path: instruction/address pair and the NOP word.
package fetch_queue_pkg;
   localparam int FQ_DATA_W = 32;
   localparam logic [FQ_DATA_W-1:0] NOP_INSTR = 32'h00000000;

   typedef struct packed {
      logic [FQ_DATA_W-1:0] instruction;
      logic [FQ_DATA_W-1:0] address;
   } fetch_pair_t;
endpackage

// File: rtl/fetch_queue_mem.sv
// Register-array storage for the fetch queue: synchronous write, asynchronous read, no reset.
module fetch_queue_mem #(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2,
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue between fetch and decode; flush discards all held entries.
// Define FETCH_QUEUE_BYPASS_EN to forward input straight to output when the queue is empty.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2,
   parameter int DATA_W = FQ_DATA_W
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_instruction,
   input  logic [DATA_W-1:0] in_address,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_instruction,
   output logic [DATA_W-1:0] out_address,
   output logic [PTR_W:0]    count
);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0]    wr_ptr, rd_ptr;
   logic [PTR_W:0]      count_q;
   logic [2*DATA_W-1:0] rd_data;
   logic                stored, bypass, push, pop;

   assign stored   = (count_q != '0);
   assign in_ready = (count_q != FULL);

`ifdef FETCH_QUEUE_BYPASS_EN
   assign bypass = !stored && in_valid && !flush;
`else
   assign bypass = 1'b0;
`endif

   // A bypassed entry taken by decode in the same cycle never lands in storage.
   assign push = in_valid && in_ready && !flush && !(bypass && out_ready);
   assign pop  = stored && out_ready && !flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   fetch_queue_mem #(.DEPTH(DEPTH), .PTR_W(PTR_W), .WIDTH(2*DATA_W)) u_mem (
      .clock   (clock),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data ({in_instruction, in_address}),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

   always_comb begin
      out_valid       = stored || bypass;
      out_instruction = DATA_W'(NOP_INSTR);
      out_address     = '0;
      if (stored) begin
         out_instruction = rd_data[2*DATA_W-1:DATA_W];
         out_address     = rd_data[DATA_W-1:0];
      end else if (bypass) begin
         out_instruction = in_instruction;
         out_address     = in_address;
      end
   end

   assign count = count_q;

   a_count_range: assert property (@(posedge clock) disable iff (reset) count_q <= FULL);
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a queue-based reference model checked every cycle.
module tb_fetch_queue;
   import fetch_queue_pkg::*;

   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [31:0] in_instruction, in_address;
   logic        in_ready, out_valid;
   logic [31:0] out_instruction, out_address;
   logic [2:0]  count;

   int tests = 0;
   int fails = 0;

   fetch_queue #(.DEPTH(4), .PTR_W(2), .DATA_W(32)) dut (
      .clock(clock), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instruction(in_instruction), .in_address(in_address),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instruction(out_instruction), .out_address(out_address),
      .count(count)
   );

   always #5 clock = ~clock;

`ifdef FETCH_QUEUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   // Reference model: a plain FIFO of pairs.
   fetch_pair_t mq[$];

   always @(posedge clock or posedge reset) begin
      if (reset || flush) mq.delete();
      else begin
         automatic bit had = (mq.size() != 0);
         automatic bit room = (mq.size() < DEPTH);
         if (had && out_ready) void'(mq.pop_front());
         if (in_valid && room && !(BYP && !had && out_ready))
            mq.push_back('{instruction: in_instruction, address: in_address});
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      automatic bit byp = BYP && mq.size() == 0 && in_valid && !flush && !reset;
      automatic logic [31:0] e_i = 32'h0, e_a = 32'h0;
      if (mq.size() != 0) begin
         e_i = mq[0].instruction;
         e_a = mq[0].address;
      end else if (byp) begin
         e_i = in_instruction;
         e_a = in_address;
      end
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
      chk("m_out_valid", 32'(out_valid), 32'(mq.size() != 0 || byp));
      chk("m_out_instr", out_instruction, e_i);
      chk("m_out_addr", out_address, e_a);
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instruction = '0; in_address = '0;
      step(); step();
      reset = 1'b0;
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_instr", out_instruction, 32'h0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_count", 32'(count), 32'd0);
      step();

      // fill to full, then try a 5th push
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_address = 32'(i * 4); in_instruction = 32'h20080001 + 32'(i);
         step();
      end
      in_address = 32'h10; in_instruction = 32'h20080005;
      step();
      in_valid = 1'b0;
      #3;
      chk("full_count", 32'(count), 32'd4);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      step();

      // drain in order
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk("drain_addr", out_address, 32'(i * 4));
         chk("drain_instr", out_instruction, 32'h20080001 + 32'(i));
         step();
      end
      #3;
      chk("drained_valid", 32'(out_valid), 32'd0);
      chk("drained_instr", out_instruction, 32'h0);
      step();

      // steady push/pop across pointer wrap
      out_ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_address = 32'h100 + 32'(4 * k); in_instruction = 32'hA000 + 32'(k);
         step();
      end
      out_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         in_address = 32'h100 + 32'(4 * (j + 2)); in_instruction = 32'hA000 + 32'(j + 2);
         #3;
         chk("wrap_addr", out_address, 32'h100 + 32'(4 * j));
         chk("wrap_count", 32'(count), 32'd2);
         step();
      end

      // bring to 3 then flush with concurrent push and pop
      out_ready = 1'b0; in_address = 32'h200; in_instruction = 32'hB000;
      step();
      #3;
      chk("pre_flush_count", 32'(count), 32'd3);
      step();
      flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_address = 32'h204;
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      #3;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      step();

      // async reset between edges with two entries held
      in_valid = 1'b1; in_address = 32'h300; step();
      in_address = 32'h304; step();
      in_valid = 1'b0;
      #2;
      chk("pre_rst_count", 32'(count), 32'd2);
      reset = 1'b1;
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      step();
      reset = 1'b0;
      step();

      // empty queue, input offered with decode ready
      in_valid = 1'b1; in_address = 32'h40; in_instruction = 32'h20080040; out_ready = 1'b1;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("byp_valid", 32'(out_valid), 32'd1);
      chk("byp_addr", out_address, 32'h40);
      step();
      in_valid = 1'b0;
      #3;
      chk("byp_count", 32'(count), 32'd0);
`else
      chk("nobyp_valid", 32'(out_valid), 32'd0);
      step();
      in_valid = 1'b0; out_ready = 1'b0;
      #3;
      chk("nobyp_count", 32'(count), 32'd1);
      chk("nobyp_addr", out_address, 32'h40);
`endif
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
